// File: rtl/adder_defs.sv
// Shared definitions for the chunked adder/subtractor: FSM state encodings
// and a small helper that sizes the chunk index counter.
package adder_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one so a single-chunk
  // configuration still gets a real (if trivial) index register.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple adder built from one_bit_full_adder cells.
// Besides the carry out it exposes the carry into the top bit, which the
// parent uses to derive signed overflow on the final chunk.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // Each stage owns its own carry nets so the chain is a plain sequence of
  // distinct wires rather than a vector that feeds back into itself.
  genvar i;
  generate
    for (i = 0; i < CHUNK; i++) begin : g_bit
      logic c_in_bit;
      logic c_out_bit;

      if (i == 0) begin : g_first
        assign c_in_bit = cin;
      end else begin : g_rest
        assign c_in_bit = g_bit[i-1].c_out_bit;
      end

      one_bit_full_adder u_fa (
        .a   (a[i]),
        .b   (b[i]),
        .cin (c_in_bit),
        .sum (sum[i]),
        .cout(c_out_bit)
      );
    end
  endgenerate

  assign cout  = g_bit[CHUNK-1].c_out_bit;
  assign c_msb = g_bit[CHUNK-1].c_in_bit;

endmodule

// File: rtl/one_bit_full_adder.sv
// Single-bit full adder, the leaf cell of the chunk ripple chain.
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_adder_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor. One CHUNK-wide adder is reused
// every clock with a registered carry between chunks. Operands come in on a
// valid/ready handshake, the result (with carry, signed overflow and zero
// flags) is held on a second valid/ready handshake until it is taken.
module chunked_adder_sub
  import adder_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = clog2_min1(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Reject configurations where the chunks would not tile the word exactly.
  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_adder_sub: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;

  // Operand words shift right one chunk per RUN cycle, so the adder always
  // sees the low CHUNK bits and no wide index multiplexer is needed.
  logic [WIDTH-1:0] a_work;
  logic [WIDTH-1:0] b_work;
  logic [WIDTH-1:0] res_work;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_c_msb;
  logic [WIDTH-1:0] chunk_ext;
  logic [WIDTH-1:0] res_next;

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a    (a_work[CHUNK-1:0]),
    .b    (b_work[CHUNK-1:0]),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .c_msb(chunk_c_msb)
  );

  // New chunk result enters at the top while earlier chunks shift down; after
  // NCHUNK steps the first chunk has reached bit 0.
  always_comb begin
    chunk_ext = WIDTH'(chunk_sum);
    res_next  = (res_work >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
  end

  // Control FSM plus datapath registers; reset overrides every handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_work   <= '0;
      b_work   <= '0;
      res_work <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_work   <= a;
            b_work   <= sub ? ~b : b;
            carry    <= sub ? ~cin : cin;
            idx      <= '0;
            res_work <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_work   <= a_work >> CHUNK;
          b_work   <= b_work >> CHUNK;
          res_work <= res_next;
          carry    <= chunk_cout;
          idx      <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            sum_q  <= res_next;
            cout_q <= chunk_cout;
            ovf_q  <= chunk_cout ^ chunk_c_msb;
            zero_q <= (res_next == '0);
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_adder_sub.sv
// Scoreboard bench for chunked_adder_sub. Three instances cover CHUNK=8, 32
// and 1 on a 32-bit word; operations are issued to one instance at a time and
// a negedge monitor pops expected results as each instance hands one over.
module tb_chunked_adder_sub;

  localparam int W    = 32;
  localparam int NDUT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         in_valid  [NDUT];
  logic         out_ready [NDUT];
  logic         in_ready  [NDUT];
  logic         out_valid [NDUT];
  logic [W-1:0] sum_o     [NDUT];
  logic         cout_o    [NDUT];
  logic         ovf_o     [NDUT];
  logic         zero_o    [NDUT];

  typedef struct {
    int           id;
    string        name;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_cnt    = 0;
  int accept_cyc [NDUT];
  logic ov_seen  [NDUT];

  always #5 clk = ~clk;

  chunked_adder_sub #(.WIDTH(W), .CHUNK(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]),
    .zero(zero_o[0])
  );

  chunked_adder_sub #(.WIDTH(W), .CHUNK(32)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]),
    .zero(zero_o[1])
  );

  chunked_adder_sub #(.WIDTH(W), .CHUNK(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]),
    .zero(zero_o[2])
  );

  function automatic int lat_of(input int id);
    case (id)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Track the accepting edge of each instance and count clock edges.
  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    for (int i = 0; i < NDUT; i++) begin
      if (!reset && in_valid[i] && in_ready[i]) begin
        accept_cyc[i] <= cycle_cnt + 1;
      end
    end
  end

  // Monitor: check latency when a result first appears, and compare it
  // against the scoreboard when the consumer takes it.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      if (out_valid[i] === 1'b1 && !ov_seen[i]) begin
        checkOutput($sformatf("latency dut%0d", i), cycle_cnt - accept_cyc[i], lat_of(i));
      end
      ov_seen[i] = (out_valid[i] === 1'b1);
      if (out_valid[i] === 1'b1 && out_ready[i]) begin
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected result dut%0d: got sum 0x%08h, expected no result", i, sum_o[i]);
        end else begin
          e = sb_q.pop_front();
          checkOutput($sformatf("%s id", e.name), i, e.id);
          checkOutput($sformatf("%s sum", e.name), sum_o[i], e.sum);
          checkFlag($sformatf("%s cout", e.name), cout_o[i], e.cout);
          checkFlag($sformatf("%s ovf", e.name), ovf_o[i], e.ovf);
          checkFlag($sformatf("%s zero", e.name), zero_o[i], e.zero);
        end
      end
    end
  end

  // Present one operation to instance id and hold it until accepted.
  task automatic applyStimulus(input int id, input string name, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic cv, input logic sv,
                               input logic push, input logic [W-1:0] esum, input logic ecout,
                               input logic eovf, input logic ezero);
    exp_t e;
    int   n;
    a = av;
    b = bv;
    cin = cv;
    sub = sv;
    in_valid[id] = 1'b1;
    n = 0;
    while (!in_ready[id] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[id]) begin
      checkFlag($sformatf("%s accept timeout", name), in_ready[id], 1'b1);
      in_valid[id] = 1'b0;
      return;
    end
    if (push) begin
      e.id = id; e.name = name; e.sum = esum; e.cout = ecout; e.ovf = eovf; e.zero = ezero;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid[id] = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checkOutput($sformatf("%s drain timeout", name), sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic runVec(input int id, input string name, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic cv, input logic sv,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf,
                        input logic ezero);
    applyStimulus(id, name, av, bv, cv, sv, 1'b1, esum, ecout, eovf, ezero);
    waitDrain(name);
  endtask

  initial begin
    int   n;
    logic bad;

    reset = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      in_valid[i]   = 1'b0;
      out_ready[i]  = 1'b1;
      accept_cyc[i] = 0;
      ov_seen[i]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset state of every instance.
    for (int i = 0; i < NDUT; i++) begin
      checkFlag($sformatf("reset in_ready dut%0d", i), in_ready[i], 1'b1);
      checkFlag($sformatf("reset out_valid dut%0d", i), out_valid[i], 1'b0);
      checkOutput($sformatf("reset sum dut%0d", i), sum_o[i], 32'h0);
      checkFlag($sformatf("reset cout dut%0d", i), cout_o[i], 1'b0);
      checkFlag($sformatf("reset ovf dut%0d", i), ovf_o[i], 1'b0);
      checkFlag($sformatf("reset zero dut%0d", i), zero_o[i], 1'b0);
    end

    // Directed vectors on every chunk width; results must be identical.
    for (int i = 0; i < NDUT; i++) begin
      runVec(i, $sformatf("wrap d%0d", i), 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      runVec(i, $sformatf("addovf d%0d", i), 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      runVec(i, $sformatf("subovf d%0d", i), 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      runVec(i, $sformatf("borrow d%0d", i), 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      runVec(i, $sformatf("subzero d%0d", i), 32'h0000_0005, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      runVec(i, $sformatf("subcin d%0d", i), 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      runVec(i, $sformatf("mixed d%0d", i), 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 1'b0);
    end

    // Backpressure on the CHUNK=8 instance: result must hold while inputs wiggle.
    out_ready[0] = 1'b0;
    applyStimulus(0, "bp", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkFlag("bp out_valid rise", out_valid[0], 1'b1);
    for (int k = 0; k < 10; k++) begin
      a = $urandom;
      b = $urandom;
      in_valid[0] = k[0];
      @(posedge clk); #1;
      checkFlag($sformatf("bp out_valid c%0d", k), out_valid[0], 1'b1);
      checkFlag($sformatf("bp in_ready c%0d", k), in_ready[0], 1'b0);
      checkOutput($sformatf("bp sum c%0d", k), sum_o[0], 32'h0001_0000);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    checkFlag("bp idle in_ready", in_ready[0], 1'b1);
    checkFlag("bp idle out_valid", out_valid[0], 1'b0);
    checkOutput("bp queue empty", sb_q.size(), 0);
    runVec(0, "after bp", 32'h0000_0010, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_000D, 1'b1, 1'b0, 1'b0);

    // Reset during RUN cycle 2: the aborted result must never appear.
    applyStimulus(0, "abort", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkFlag("abort in_ready", in_ready[0], 1'b1);
    checkFlag("abort out_valid", out_valid[0], 1'b0);
    checkOutput("abort sum cleared", sum_o[0], 32'h0);

    // Reset together with in_valid: the operand must not be accepted.
    a = 32'h0000_0001; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
    reset = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid[0] = 1'b0;
    checkFlag("reset wins in_ready", in_ready[0], 1'b1);

    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0) bad = 1'b1;
    end
    checkFlag("abort no out_valid", bad, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
